la_vdemux7_buf: RTL and testbench
=================================

Name: la_vdemux7_buf

Overview:
- 7-output, one-hot-steered, buffered demultiplexer with valid/ready flow control on both sides.
- Mirrors the 7-input one-hot vectorized mux: a single N-bit stream enters and is routed to exactly one of 7 consumers.
- Sits in the vectorlib layer, typically feeding bank- or lane-steering logic.
- A 2-entry buffer decouples input acceptance from output backpressure; malformed selects are dropped and counted.

Parameters:
N, 1, data width
CW, 8, width of saturating error counter
PROP, "DEFAULT", cell property passthrough

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  buffer can accept input
in_sel  input  7  one-hot destination select, bit k = output k
in_data  input  N  input data word
out_valid  output  7  one-hot valid; bit k = word for consumer k
out_ready  input  7  per-consumer ready
out_data  output  N  data of head entry, shared by all consumers
err  output  1  one-cycle pulse: non-one-hot select dropped
err_cnt  output  CW  saturating count of dropped words

Behaviour:
- Reset (async assert, sync release):
  - buffer count=0, out_valid=0, out_data=0, err=0, err_cnt=0.
  - in_ready=0 while reset is high; in_ready=1 from the first rising edge after release.
- Storage: 2-entry FIFO holding {sel[6:0], data[N-1:0]}; count is 0..2.
- in_ready is registered: in_ready = (next count != 2). It never depends combinationally on out_ready.
- Input transfer (in_fire) = in_valid & in_ready.
  - If in_sel is one-hot, push the entry.
  - If in_sel is zero or has more than one bit set, consume the word without storing it. err=1 on the next cycle for exactly one cycle. err_cnt increments and saturates at 2^CW-1.
  - in_sel and in_data are don't-care when in_valid=0.
- Output presentation (registered from FIFO head):
  - out_valid = head.sel when count>0, else 7'b0.
  - out_data = head.data. It holds its last value when empty and is never cleared after reset.
- Output transfer (out_fire) = |(out_valid & out_ready). Only the ready bit of the selected consumer matters; other out_ready bits are ignored.
- Stability: while out_valid!=0 and not fired, out_valid and out_data hold constant.
- Latency: a word accepted in cycle t with count=0 appears on out_valid/out_data in cycle t+1.
- Throughput:
  - 1 word/cycle sustained when the selected consumer holds ready=1.
  - Destination changes word-to-word without bubbles.
- Count update:
  - push & pop: count unchanged.
  - push only: +1.
  - pop only: -1.
  - Push cannot occur at count=2 because in_ready=0.
- Full boundary: count=2 with out_fire in the same cycle gives in_ready=1 in the next cycle. There is no same-cycle pass-through.
- Empty boundary: count=0 with a push gives no output in the same cycle.
- Dropped-word interactions:
  - A dropped word does not change count.
  - A simultaneous out_fire still pops normally.
- err_cnt saturation: when err_cnt is at max, err still pulses and err_cnt holds.
- Mid-operation reset: all buffered entries are discarded immediately. out_valid goes to 0 asynchronously and no partial transfer completes.
- Ordering: strict FIFO across all destinations. A stalled head blocks later words bound for other consumers; this is intentional and provides no bypass.

Test Plan:
- Reset then idle, N=8:
  - During reset: in_ready=0, out_valid=0, err_cnt=0.
  - One cycle after release: in_ready=1.
- Single word: in_sel=7'b0000100, in_data=8'hA5, out_ready=7'h7F -> next cycle out_valid=7'b0000100 and out_data=8'hA5, then out_valid=0.
- Streaming: back-to-back words to outputs 0,6,3,1 (data 8'h10..8'h13), all out_ready=1 -> outputs in order on consecutive cycles, in_ready stays 1, no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 while 3 words are offered to output 5.
  - Required: first 2 accepted, in_ready=0, third held.
  - Raise out_ready[5] only -> words drain in order; in_ready returns 1 the cycle after the first pop.
  - Holding out_ready[2]=1 instead must drain nothing.
- Bad select: in_sel=7'b0000000, then 7'b0011000 -> two err pulses, err_cnt=2, nothing appears on out_valid, count unchanged.
  - With CW=2, five bad words -> err_cnt saturates at 3.
- Reset mid-operation: with 2 words buffered, assert reset asynchronously mid-cycle -> out_valid=0 immediately, and after release the FIFO is empty with no stale output.

Source files
------------

// File: rtl/la_vdemux7_buf.sv
// la_vdemux7_buf
// Buffered 1-to-7 demultiplexer. A single N-bit stream is steered by a
// one-hot select to exactly one of seven consumers. A 2-entry FIFO sits
// between the input and output handshakes so input acceptance never depends
// combinationally on consumer readiness. Words whose select is not one-hot
// are consumed, dropped, flagged with a one-cycle err pulse and counted in a
// saturating counter.
//
// Ordering is strictly FIFO across all destinations: a stalled head blocks
// later words even if they are bound for a ready consumer.

module la_vdemux7_buf #(
   parameter int N    = 1,
   parameter int CW   = 8,
   parameter     PROP = "DEFAULT"
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [6:0]    in_sel,
   input  logic [N-1:0]  in_data,
   output logic [6:0]    out_valid,
   input  logic [6:0]    out_ready,
   output logic [N-1:0]  out_data,
   output logic          err,
   output logic [CW-1:0] err_cnt
);

   // Cell property is carried for library compatibility only; it has no
   // effect on behaviour.
   logic w_unusedProp;
   assign w_unusedProp = (PROP == "DEFAULT");

   // Storage: two entries of {sel, data} addressed by 1-bit pointers
   logic [6:0]    r_memSel  [2];
   logic [N-1:0]  r_memData [2];
   logic          r_wrPtr;
   logic          r_rdPtr;
   logic [1:0]    r_count;

   // Registered output and status state
   logic [6:0]    r_outValid;
   logic [N-1:0]  r_outData;
   logic          r_inReady;
   logic          r_err;
   logic [CW-1:0] r_errCnt;

   // Handshake and next-state helpers
   logic          w_selOneHot;
   logic          w_inFire;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic [1:0]    w_nextCount;
   logic          w_nextRdPtr;
   logic          w_headFromInput;
   logic [6:0]    w_nextHeadSel;
   logic [N-1:0]  w_nextHeadData;

   // A select is legal only when exactly one bit is set; the
   // clear-lowest-bit trick avoids a population count.
   assign w_selOneHot = (in_sel != 7'd0) && ((in_sel & (in_sel - 7'd1)) == 7'd0);

   // Input side: accepted words either enter the FIFO or are dropped.
   assign w_inFire = in_valid & r_inReady;
   assign w_push   = w_inFire & w_selOneHot;
   assign w_drop   = w_inFire & ~w_selOneHot;

   // Output side: r_outValid is zero whenever the FIFO is empty, so only the
   // ready bit of the selected consumer can cause a pop.
   assign w_pop = |(r_outValid & out_ready);

   // Occupancy after this cycle's push/pop. Push is impossible at count 2
   // because r_inReady is low there.
   always_comb begin
      w_nextCount = r_count;
      case ({w_push, w_pop})
         2'b10:   w_nextCount = r_count + 2'd1;
         2'b01:   w_nextCount = r_count - 2'd1;
         default: w_nextCount = r_count;
      endcase
   end

   assign w_nextRdPtr = r_rdPtr ^ w_pop;

   // The next head is the word being pushed right now exactly when the next
   // read slot is the slot being written this cycle (FIFO empty, or one entry
   // that is popping while a new one arrives). Otherwise it is already stored.
   assign w_headFromInput = w_push && (w_nextRdPtr == r_wrPtr);

   always_comb begin
      w_nextHeadSel  = r_memSel[w_nextRdPtr];
      w_nextHeadData = r_memData[w_nextRdPtr];
      if (w_headFromInput) begin
         w_nextHeadSel  = in_sel;
         w_nextHeadData = in_data;
      end
   end

   // Write the pushed entry into the slot under the write pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_memSel[0]  <= 7'd0;
         r_memSel[1]  <= 7'd0;
         r_memData[0] <= '0;
         r_memData[1] <= '0;
      end else if (w_push) begin
         r_memSel[r_wrPtr]  <= in_sel;
         r_memData[r_wrPtr] <= in_data;
      end
   end

   // Advance pointers and occupancy; reset discards every buffered entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_wrPtr <= r_wrPtr ^ w_push;
         r_rdPtr <= w_nextRdPtr;
         r_count <= w_nextCount;
      end
   end

   // in_ready is a register of next-cycle space, so it is low during reset,
   // rises on the first edge after release and never follows out_ready
   // combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inReady <= 1'b0;
      end else begin
         r_inReady <= (w_nextCount != 2'd2);
      end
   end

   // Present the next head on the registered outputs. out_valid clears when
   // the FIFO empties but out_data keeps its last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_outValid <= 7'd0;
         r_outData  <= '0;
      end else begin
         if (w_nextCount != 2'd0) begin
            r_outValid <= w_nextHeadSel;
            r_outData  <= w_nextHeadData;
         end else begin
            r_outValid <= 7'd0;
         end
      end
   end

   // Dropped words pulse err for one cycle and bump a saturating counter;
   // the pulse still fires once the counter has hit its ceiling.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err    <= 1'b0;
         r_errCnt <= '0;
      end else begin
         r_err <= w_drop;
         if (w_drop && (r_errCnt != {CW{1'b1}})) begin
            r_errCnt <= r_errCnt + CW'(1);
         end
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign err       = r_err;
   assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_la_vdemux7_buf.sv
// tb_la_vdemux7_buf
// Directed bench for la_vdemux7_buf. Stimulus pushes the words it expects to
// be delivered into a queue; an independent monitor pops and compares
// whenever a consumer transfer happens. A second instance with a 2-bit error
// counter exercises saturation.

module tb_la_vdemux7_buf;

   logic       clk;
   logic       reset;

   // Main instance, N=8, CW=8
   logic       inValid;
   logic       inReady;
   logic [6:0] inSel;
   logic [7:0] inData;
   logic [6:0] outValid;
   logic [6:0] outReady;
   logic [7:0] outData;
   logic       err;
   logic [7:0] errCnt;

   // Saturation instance, N=8, CW=2
   logic       satValid;
   logic       satReady;
   logic [6:0] satSel;
   logic [7:0] satData;
   logic [6:0] satOutValid;
   logic [7:0] satOutData;
   logic       satErr;
   logic [1:0] satErrCnt;

   int checkCount;
   int failCount;
   int popCount;
   int stalls;

   logic [14:0] expQ[$];

   la_vdemux7_buf #(.N(8), .CW(8), .PROP("DEFAULT")) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_sel    (inSel),
      .in_data   (inData),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .err       (err),
      .err_cnt   (errCnt)
   );

   la_vdemux7_buf #(.N(8), .CW(2), .PROP("DEFAULT")) dutSat (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (satValid),
      .in_ready  (satReady),
      .in_sel    (satSel),
      .in_data   (satData),
      .out_valid (satOutValid),
      .out_ready (7'h7F),
      .out_data  (satOutData),
      .err       (satErr),
      .err_cnt   (satErrCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its required value
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Offer one word (called just after a rising edge); returns just after the
   // edge on which it was accepted, leaving in_valid asserted so callers can
   // stream back-to-back. Words that should reach a consumer are queued.
   task automatic applyStimulus(input logic [6:0] sel, input logic [7:0] data,
                                input bit store, output int stallCycles);
      inValid     = 1'b1;
      inSel       = sel;
      inData      = data;
      stallCycles = 0;
      @(negedge clk);
      while (!inReady && stallCycles < 20) begin
         stallCycles++;
         @(negedge clk);
      end
      if (!inReady) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
      end else if (store) begin
         expQ.push_back({sel, data});
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every consumer transfer must match the queue head
   always @(negedge clk) begin
      if (!reset && ((outValid & outReady) != 7'd0)) begin
         if (expQ.size() == 0) begin
            checkOutput("sbUnexpected", {17'd0, outValid, outData}, 32'd0);
         end else begin
            logic [14:0] exp;
            exp = expQ.pop_front();
            checkOutput("sbSel", {25'd0, outValid}, {25'd0, exp[14:8]});
            checkOutput("sbData", {24'd0, outData}, {24'd0, exp[7:0]});
            popCount++;
         end
      end
   end

   logic [6:0] streamSel [4];

   initial begin
      checkCount = 0;
      failCount  = 0;
      popCount   = 0;
      streamSel[0] = 7'b0000001;
      streamSel[1] = 7'b1000000;
      streamSel[2] = 7'b0001000;
      streamSel[3] = 7'b0000010;

      reset    = 1'b1;
      inValid  = 1'b0;
      inSel    = 7'd0;
      inData   = 8'd0;
      outReady = 7'd0;
      satValid = 1'b0;
      satSel   = 7'd0;
      satData  = 8'd0;

      // Reset state and release
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", {31'd0, inReady}, 32'd0);
      checkOutput("rstOutValid", {25'd0, outValid}, 32'd0);
      checkOutput("rstErrCnt", {24'd0, errCnt}, 32'd0);
      checkOutput("rstErr", {31'd0, err}, 32'd0);
      checkOutput("rstOutData", {24'd0, outData}, 32'd0);
      reset = 1'b0;
      #2;
      checkOutput("relInReadyBeforeEdge", {31'd0, inReady}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("relInReady", {31'd0, inReady}, 32'd1);

      // Single word with one-cycle latency
      outReady = 7'h7F;
      applyStimulus(7'b0000100, 8'hA5, 1'b1, stalls);
      inValid = 1'b0;
      checkOutput("singleValid", {25'd0, outValid}, 32'h04);
      checkOutput("singleData", {24'd0, outData}, 32'hA5);
      @(posedge clk);
      #1;
      checkOutput("singleDrained", {25'd0, outValid}, 32'd0);
      checkOutput("singleDataHold", {24'd0, outData}, 32'hA5);

      // Back-to-back streaming across destinations, no bubbles
      for (int i = 0; i < 4; i++) begin
         applyStimulus(streamSel[i], 8'(8'h10 + i), 1'b1, stalls);
         checkOutput("streamStall", stalls, 32'd0);
      end
      inValid = 1'b0;
      checkOutput("streamLastValid", {25'd0, outValid}, 32'h02);
      checkOutput("streamLastData", {24'd0, outData}, 32'h13);
      @(posedge clk);
      #1;
      checkOutput("streamDrained", {25'd0, outValid}, 32'd0);

      // Backpressure: fill, hold third word, wrong-consumer ready, then drain
      outReady = 7'd0;
      applyStimulus(7'b0100000, 8'h20, 1'b1, stalls);
      applyStimulus(7'b0100000, 8'h21, 1'b1, stalls);
      checkOutput("bpFull", {31'd0, inReady}, 32'd0);
      checkOutput("bpHeadValid", {25'd0, outValid}, 32'h20);
      checkOutput("bpHeadData", {24'd0, outData}, 32'h20);
      inValid = 1'b1;
      inSel   = 7'b0100000;
      inData  = 8'h22;
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("bpHeldReady", {31'd0, inReady}, 32'd0);
         checkOutput("bpHeldValid", {25'd0, outValid}, 32'h20);
      end
      outReady = 7'b0000100;
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("bpWrongReadyValid", {25'd0, outValid}, 32'h20);
         checkOutput("bpWrongReadyData", {24'd0, outData}, 32'h20);
         checkOutput("bpWrongReadyIn", {31'd0, inReady}, 32'd0);
      end
      outReady = 7'b0100000;
      @(negedge clk);
      checkOutput("bpReadyDuringPop", {31'd0, inReady}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bpReadyAfterPop", {31'd0, inReady}, 32'd1);
      checkOutput("bpSecondData", {24'd0, outData}, 32'h21);
      @(negedge clk);
      expQ.push_back({7'b0100000, 8'h22});
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("bpThirdData", {24'd0, outData}, 32'h22);
      @(posedge clk);
      #1;
      checkOutput("bpDrained", {25'd0, outValid}, 32'd0);
      checkOutput("bpReadyEnd", {31'd0, inReady}, 32'd1);

      // Malformed selects: zero and two-hot
      outReady = 7'h7F;
      applyStimulus(7'b0000000, 8'hEE, 1'b0, stalls);
      inValid = 1'b0;
      checkOutput("bad0Err", {31'd0, err}, 32'd1);
      checkOutput("bad0Cnt", {24'd0, errCnt}, 32'd1);
      checkOutput("bad0Valid", {25'd0, outValid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bad0ErrEnd", {31'd0, err}, 32'd0);
      checkOutput("bad0CntHold", {24'd0, errCnt}, 32'd1);
      applyStimulus(7'b0011000, 8'hDD, 1'b0, stalls);
      inValid = 1'b0;
      checkOutput("bad1Err", {31'd0, err}, 32'd1);
      checkOutput("bad1Cnt", {24'd0, errCnt}, 32'd2);
      checkOutput("bad1Valid", {25'd0, outValid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bad1ErrEnd", {31'd0, err}, 32'd0);
      checkOutput("bad1CntHold", {24'd0, errCnt}, 32'd2);
      checkOutput("bad1Valid2", {25'd0, outValid}, 32'd0);
      checkOutput("bad1Ready", {31'd0, inReady}, 32'd1);

      // Saturation of a 2-bit error counter over five bad words
      satValid = 1'b1;
      satSel   = 7'b0000011;
      for (int i = 0; i < 5; i++) begin
         satData = 8'(i);
         @(posedge clk);
         #1;
         checkOutput("satErr", {31'd0, satErr}, 32'd1);
         checkOutput("satCnt", {30'd0, satErrCnt}, (i < 3) ? (i + 1) : 3);
      end
      satValid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("satErrEnd", {31'd0, satErr}, 32'd0);
      checkOutput("satCntHold", {30'd0, satErrCnt}, 32'd3);
      checkOutput("satOutValid", {25'd0, satOutValid}, 32'd0);

      // Asynchronous reset with two words buffered
      outReady = 7'd0;
      applyStimulus(7'b0000001, 8'h55, 1'b0, stalls);
      applyStimulus(7'b1000000, 8'h66, 1'b0, stalls);
      inValid = 1'b0;
      checkOutput("midBuffered", {25'd0, outValid}, 32'h01);
      checkOutput("midFull", {31'd0, inReady}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midRstValid", {25'd0, outValid}, 32'd0);
      checkOutput("midRstReady", {31'd0, inReady}, 32'd0);
      checkOutput("midRstErrCnt", {24'd0, errCnt}, 32'd0);
      outReady = 7'h7F;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midRelReady", {31'd0, inReady}, 32'd1);
      repeat (3) begin
         checkOutput("midNoStale", {25'd0, outValid}, 32'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("midOutData", {24'd0, outData}, 32'd0);

      // Everything queued must have been delivered, exactly once
      checkOutput("sbDrained", expQ.size(), 32'd0);
      checkOutput("sbPopCount", popCount, 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
